// File: rtl/fsm_status_tx_pkg.sv
// Shared constants and types for the UART status reporter: ASCII codes,
// stopwatch mode encodings (same as the command FSM), FSM states and
// small helpers for mode decode and message lettering.
package fsm_status_tx_pkg;

    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_U  = 8'h55;
    localparam logic [7:0] ASCII_N  = 8'h4E;
    localparam logic [7:0] ASCII_S  = 8'h53;
    localparam logic [7:0] ASCII_T  = 8'h54;
    localparam logic [7:0] ASCII_P  = 8'h50;
    localparam logic [7:0] ASCII_C  = 8'h43;
    localparam logic [7:0] ASCII_L  = 8'h4C;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Largest value that fits in four decimal digits.
    localparam int MAX_COUNT = 9999;

    typedef enum logic [1:0] {
        MODE_STOP = 2'b00,
        MODE_RUN  = 2'b01,
        MODE_CLR  = 2'b10
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CAPTURE   = 3'd1,
        ST_CONV      = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_ACK  = 3'd4,
        ST_WAIT_DONE = 3'd5
    } state_e;

    // Clear wins over run; neither flag means the stopwatch is stopped.
    function automatic mode_e decode_mode(input logic run_on, input logic clr_on);
        if (clr_on)      return MODE_CLR;
        else if (run_on) return MODE_RUN;
        else             return MODE_STOP;
    endfunction

    // Three-letter mode name: "RUN", "STP" or "CLR", selected by letter position.
    function automatic logic [7:0] mode_letter(input mode_e m, input logic [1:0] pos);
        logic [7:0] ch;
        ch = ASCII_S;
        case (m)
            MODE_RUN: begin
                case (pos)
                    2'd0:    ch = ASCII_R;
                    2'd1:    ch = ASCII_U;
                    default: ch = ASCII_N;
                endcase
            end
            MODE_CLR: begin
                case (pos)
                    2'd0:    ch = ASCII_C;
                    2'd1:    ch = ASCII_L;
                    default: ch = ASCII_R;
                endcase
            end
            default: begin
                case (pos)
                    2'd0:    ch = ASCII_S;
                    2'd1:    ch = ASCII_T;
                    default: ch = ASCII_P;
                endcase
            end
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/fsm_status_tx_if.sv
// Byte-wide start/busy handshake between the status reporter (master)
// and the UART transmitter (slave).
interface fsm_status_tx_if;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       i_tx_busy;

    modport master (
        output o_tx_data,
        output o_tx_start,
        input  i_tx_busy
    );

    modport slave (
        input  o_tx_data,
        input  o_tx_start,
        output i_tx_busy
    );
endinterface

// File: rtl/fsm_status_tx_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter. A start pulse loads the
// binary value; COUNT_W cycles later done pulses and o_bcd holds four digits
// (o_bcd[3] is thousands). The result is held until the next start.
module bin2bcd_seq #(
    parameter int COUNT_W = 14
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    input  logic [COUNT_W-1:0]  i_bin,
    output logic                o_done,
    output logic [3:0][3:0]     o_bcd
);

    localparam int CNT_W = $clog2(COUNT_W + 1);

    logic [COUNT_W-1:0] shift_q, shift_d;
    logic [3:0][3:0]    bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [3:0][3:0]    adj;

    // Converter registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // One double-dabble step per cycle: add 3 to digits >= 5, then shift in the next bit.
    always_comb begin
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        adj     = bcd_q;
        if (i_start) begin
            shift_d = i_bin;
            bcd_d   = '0;
            cnt_d   = CNT_W'(COUNT_W);
            busy_d  = 1'b1;
        end else if (busy_q) begin
            for (int k = 0; k < 4; k++) begin
                adj[k] = (bcd_q[k] >= 4'd5) ? (bcd_q[k] + 4'd3) : bcd_q[k];
            end
            {bcd_d, shift_d} = {adj, shift_q} << 1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    assign o_done = done_q;
    assign o_bcd  = bcd_q;

endmodule

// File: rtl/fsm_status_tx.sv
// UART status reporter. Reports stopwatch mode changes automatically and
// the counter value on request, one ASCII byte at a time over a start/busy
// handshake. Events are remembered in one-deep pending flags, so anything
// arriving while a message is in flight is queued, never mixed in.
module fsm_status_tx #(
    parameter int COUNT_W  = 14,
    parameter bit EOL_CRLF = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_run_on,
    input  logic                i_clr_on,
    input  logic [COUNT_W-1:0]  i_count,
    input  logic                i_report_req,
    fsm_status_tx_if.master     tx,
    output logic                o_busy
);

    import fsm_status_tx_pkg::*;

    // Index of the final EOL byte for each message kind.
    localparam logic [2:0] MODE_LAST = EOL_CRLF ? 3'd4 : 3'd3;
    localparam logic [2:0] RPT_LAST  = EOL_CRLF ? 3'd6 : 3'd5;

    state_e     state_q, state_d;
    mode_e      prev_mode_q, prev_mode_d;
    mode_e      msg_mode_q, msg_mode_d;
    logic       mode_pend_q, mode_pend_d;
    logic       rpt_pend_q, rpt_pend_d;
    logic       msg_is_rpt_q, msg_is_rpt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_start_q, tx_start_d;

    mode_e              cur_mode;
    logic               mode_evt;
    logic               conv_start;
    logic               conv_done;
    logic [3:0][3:0]    bcd;
    logic [COUNT_W-1:0] count_sat;
    logic [7:0]         cur_char;
    logic [2:0]         last_idx;

    // Counts beyond four digits are shown as 9999.
    assign count_sat = (32'(i_count) > 32'(MAX_COUNT)) ? COUNT_W'(MAX_COUNT) : i_count;

    bin2bcd_seq #(
        .COUNT_W (COUNT_W)
    ) u_bcd (
        .clk     (clk),
        .reset   (reset),
        .i_start (conv_start),
        .i_bin   (count_sat),
        .o_done  (conv_done),
        .o_bcd   (bcd)
    );

    // State, pending flags, mode history and transmitter outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            prev_mode_q  <= MODE_STOP;
            msg_mode_q   <= MODE_STOP;
            mode_pend_q  <= 1'b0;
            rpt_pend_q   <= 1'b0;
            msg_is_rpt_q <= 1'b0;
            idx_q        <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_mode_q  <= prev_mode_d;
            msg_mode_q   <= msg_mode_d;
            mode_pend_q  <= mode_pend_d;
            rpt_pend_q   <= rpt_pend_d;
            msg_is_rpt_q <= msg_is_rpt_d;
            idx_q        <= idx_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
        end
    end

    // Character at the current index of the latched message.
    always_comb begin
        cur_char = ASCII_LF;
        last_idx = msg_is_rpt_q ? RPT_LAST : MODE_LAST;
        if (msg_is_rpt_q) begin
            case (idx_q)
                3'd0:    cur_char = ASCII_C;
                3'd1:    cur_char = ASCII_0 + {4'b0000, bcd[3]};
                3'd2:    cur_char = ASCII_0 + {4'b0000, bcd[2]};
                3'd3:    cur_char = ASCII_0 + {4'b0000, bcd[1]};
                3'd4:    cur_char = ASCII_0 + {4'b0000, bcd[0]};
                3'd5:    cur_char = EOL_CRLF ? ASCII_CR : ASCII_LF;
                default: cur_char = ASCII_LF;
            endcase
        end else begin
            if (idx_q < 3'd3)       cur_char = mode_letter(msg_mode_q, idx_q[1:0]);
            else if (idx_q == 3'd3) cur_char = EOL_CRLF ? ASCII_CR : ASCII_LF;
            else                    cur_char = ASCII_LF;
        end
    end

    // Next-state logic: event capture, message selection and the byte handshake.
    always_comb begin
        state_d      = state_q;
        msg_mode_d   = msg_mode_q;
        mode_pend_d  = mode_pend_q;
        rpt_pend_d   = rpt_pend_q;
        msg_is_rpt_d = msg_is_rpt_q;
        idx_d        = idx_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        conv_start   = 1'b0;

        cur_mode    = decode_mode(i_run_on, i_clr_on);
        mode_evt    = (cur_mode != prev_mode_q);
        prev_mode_d = cur_mode;

        case (state_q)
            ST_IDLE: begin
                if (mode_pend_q || rpt_pend_q) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                idx_d = '0;
                if (mode_pend_q) begin
                    mode_pend_d  = 1'b0;
                    msg_is_rpt_d = 1'b0;
                    msg_mode_d   = prev_mode_q;
                    state_d      = ST_SEND;
                end else begin
                    rpt_pend_d   = 1'b0;
                    msg_is_rpt_d = 1'b1;
                    conv_start   = 1'b1;
                    state_d      = ST_CONV;
                end
            end
            ST_CONV: begin
                if (conv_done) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (!tx.i_tx_busy) begin
                    tx_data_d  = cur_char;
                    tx_start_d = 1'b1;
                    state_d    = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (tx.i_tx_busy) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (!tx.i_tx_busy) begin
                    if (idx_q == last_idx) begin
                        idx_d   = '0;
                        state_d = (mode_pend_q || rpt_pend_q) ? ST_CAPTURE : ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_SEND;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (mode_evt)     mode_pend_d = 1'b1;
        if (i_report_req) rpt_pend_d  = 1'b1;
    end

    assign tx.o_tx_data  = tx_data_q;
    assign tx.o_tx_start = tx_start_q;
    assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fsm_status_tx.sv
// Testbench for fsm_status_tx: a UART transmitter model with configurable
// busy time, and a message-level reference model that builds the expected
// byte stream as strings from the mode and report events it applies.
module tb_fsm_status_tx;

    localparam int COUNT_W  = 14;
    localparam bit EOL_CRLF = 1'b1;

    logic               clk = 1'b0;
    logic               reset;
    logic               i_run_on;
    logic               i_clr_on;
    logic [COUNT_W-1:0] i_count;
    logic               i_report_req;
    logic               o_busy;

    fsm_status_tx_if tx_if ();

    fsm_status_tx #(
        .COUNT_W  (COUNT_W),
        .EOL_CRLF (EOL_CRLF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_run_on     (i_run_on),
        .i_clr_on     (i_clr_on),
        .i_count      (i_count),
        .i_report_req (i_report_req),
        .tx           (tx_if.master),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    int         busy_cnt   = 0;
    int         busy_len   = 10;
    bit         rand_len   = 1'b0;
    bit         watch_busy = 1'b0;
    int         busy_drops = 0;
    int         viol       = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         n_tests    = 0;
    int         n_fail     = 0;
    int         model_mode = 0;

    assign tx_if.i_tx_busy = (busy_cnt != 0);

    // Transmitter model: records every started byte and stays busy for a while.
    always @(negedge clk) begin
        if (tx_if.o_tx_start) begin
            if (busy_cnt != 0) viol++;
            got_q.push_back(tx_if.o_tx_data);
            busy_cnt = rand_len ? int'($urandom_range(1, 12)) : busy_len;
        end else if (busy_cnt != 0) begin
            busy_cnt--;
        end
        if (watch_busy && !o_busy) busy_drops++;
    end

    task automatic checkOutput(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // 0 = stopped, 1 = running, 2 = clear (clear wins).
    function automatic int tb_mode(input logic run, input logic clr);
        return clr ? 2 : (run ? 1 : 0);
    endfunction

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
        if (EOL_CRLF) exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic push_mode_msg(input int m);
        if (m == 2)      push_str("CLR");
        else if (m == 1) push_str("RUN");
        else             push_str("STP");
    endtask

    task automatic push_rpt_msg(input int c);
        int v;
        v = (c > 9999) ? 9999 : c;
        push_str($sformatf("C%0d%0d%0d%0d", (v / 1000) % 10, (v / 100) % 10, (v / 10) % 10, v % 10));
    endtask

    task automatic applyStimulus(input logic run, input logic clr, input int count, input logic rpt);
        int m;
        @(negedge clk);
        i_run_on     = run;
        i_clr_on     = clr;
        i_count      = COUNT_W'(count);
        i_report_req = rpt;
        m = tb_mode(run, clr);
        if (m != model_mode) begin
            push_mode_msg(m);
            model_mode = m;
        end
        if (rpt) push_rpt_msg(count);
        @(negedge clk);
        i_report_req = 1'b0;
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        int cyc;
        cyc = 0;
        while (got_q.size() < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= budget) checkOutput({tag, "_timeout"}, got_q.size(), n);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int cyc;
        cyc = 0;
        while ((o_busy || got_q.size() < exp_q.size()) && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= budget) checkOutput({tag, "_timeout"}, cyc, 0);
        repeat (30) @(negedge clk);
    endtask

    task automatic compare_msgs(input string tag);
        int n;
        checkOutput({tag, "_len"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s_byte%0d", tag, i), int'(got_q[i]), int'(exp_q[i]));
        checkOutput({tag, "_start_while_busy"}, viol, 0);
        got_q.delete();
        exp_q.delete();
        viol = 0;
    endtask

    initial begin
        int bad;
        reset        = 1'b0;
        i_run_on     = 1'b0;
        i_clr_on     = 1'b0;
        i_count      = '0;
        i_report_req = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_data", int'(tx_if.o_tx_data), 0);
        checkOutput("rst_start", int'(tx_if.o_tx_start), 0);
        checkOutput("rst_busy", int'(o_busy), 0);
        reset = 1'b1;

        // Abort a RUN message after its second byte has started.
        applyStimulus(1'b1, 1'b0, 0, 1'b0);
        wait_bytes("abort", 2, 400);
        @(negedge clk);
        #1 reset = 1'b0;
        i_run_on = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (tx_if.o_tx_start || o_busy || tx_if.o_tx_data != 8'h00) bad++;
        end
        checkOutput("abort_outputs_quiet", bad, 0);
        checkOutput("abort_len", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            checkOutput("abort_byte0", int'(got_q[0]), 8'h52);
            checkOutput("abort_byte1", int'(got_q[1]), 8'h55);
        end
        got_q.delete();
        exp_q.delete();
        viol       = 0;
        model_mode = 0;
        reset      = 1'b1;
        repeat (200) @(negedge clk);
        checkOutput("post_reset_silent", got_q.size(), 0);
        checkOutput("post_reset_busy", int'(o_busy), 0);
        got_q.delete();

        // Run rises with a fixed 10-cycle byte time.
        applyStimulus(1'b1, 1'b0, 0, 1'b0);
        wait_idle("run", 2000);
        compare_msgs("run");

        rand_len = 1'b1;
        applyStimulus(1'b1, 1'b0, 37, 1'b1);
        wait_idle("rpt37", 2000);
        compare_msgs("rpt37");

        applyStimulus(1'b1, 1'b0, 12000, 1'b1);
        wait_idle("rpt_sat", 2000);
        compare_msgs("rpt_sat");

        // Run falls together with a report request: two messages, busy never drops.
        applyStimulus(1'b0, 1'b0, 5, 1'b1);
        bad = 0;
        while (!o_busy && bad < 50) begin
            @(negedge clk);
            bad++;
        end
        checkOutput("stp_rpt_busy_rise", int'(o_busy), 1);
        watch_busy = 1'b1;
        wait_bytes("stp_rpt", exp_q.size(), 2000);
        watch_busy = 1'b0;
        wait_idle("stp_rpt", 2000);
        checkOutput("stp_rpt_busy_drops", busy_drops, 0);
        compare_msgs("stp_rpt");

        // Clear overrides run; three report pulses during the message merge into one.
        applyStimulus(1'b1, 1'b1, 421, 1'b0);
        wait_bytes("clr_merge", 1, 400);
        repeat (3) begin
            @(negedge clk);
            i_report_req = 1'b1;
            @(negedge clk);
            i_report_req = 1'b0;
            repeat (5) @(negedge clk);
        end
        push_rpt_msg(421);
        wait_idle("clr_merge", 3000);
        compare_msgs("clr_merge");

        // Random mode/report combinations.
        for (int it = 0; it < 12; it++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, 16383)), 1'($urandom_range(0, 1)));
            wait_idle("rand", 3000);
            compare_msgs($sformatf("rand%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
